// File: rtl/pipe_stage2_collector_if.sv
// Stage-2 collector bus: pipe-side sample inputs plus the writeback-side
// valid/ready drain port. The slave modport is the collector's view and the
// master modport is the driver's (pipe + writeback) view.
//   start_i      arm collection (1-cycle pulse)
//   stage_i      current pipe stage
//   finished_i   pipe reached stage 7
//   operand1_i   per-lane operand1 (sqrt, div_mul or center id)
//   operand2_i   per-lane operand2 (dnorm)
//   out_ready_i  consumer accepts head entry
//   stall_o      backpressure to the pipe
//   out_valid_o  head entry valid
//   out_data_o   head entry, lane i at [i*2W +: 2W] as {operand1, operand2}
//   out_stage_o  stage tag of head entry
//   count_o      FIFO occupancy
//   done_o       drain complete pulse
//   overflow_o   sticky: an entry was lost
interface pipe_stage2_collector_if #(
    parameter int PARALLEL = 2,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                          start_i;
    logic [2:0]                    stage_i;
    logic                          finished_i;
    logic [PARALLEL*WIDTH-1:0]     operand1_i;
    logic [PARALLEL*WIDTH-1:0]     operand2_i;
    logic                          out_ready_i;
    logic                          stall_o;
    logic                          out_valid_o;
    logic [PARALLEL*2*WIDTH-1:0]   out_data_o;
    logic [2:0]                    out_stage_o;
    logic [CW-1:0]                 count_o;
    logic                          done_o;
    logic                          overflow_o;

    modport slave (
        input  start_i, stage_i, finished_i, operand1_i, operand2_i, out_ready_i,
        output stall_o, out_valid_o, out_data_o, out_stage_o, count_o, done_o, overflow_o
    );

    modport master (
        output start_i, stage_i, finished_i, operand1_i, operand2_i, out_ready_i,
        input  stall_o, out_valid_o, out_data_o, out_stage_o, count_o, done_o, overflow_o
    );
endinterface

// File: rtl/pipe_stage2_collector.sv
// Receiving end of the stage-2 operand pipe. Captures beats from selected
// stages into a tagged first-word-fall-through FIFO and drains them to the
// writeback unit over valid/ready.
//   CLK_i  clock
//   RST_i  asynchronous active-high reset
//   bus    pipe_stage2_collector_if.slave (see interface header for signals)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start_i, outputs quiet
// S_COLLECT | sampling the pipe each cycle, FIFO may drain concurrently
// S_DRAIN   | pipe finished, emptying remaining entries
// S_DONE    | one cycle: done_o pulse, then back to idle
module pipe_stage2_collector #(
    parameter int         PARALLEL     = 2,
    parameter int         WIDTH        = 16,
    parameter int         DEPTH        = 8,
    parameter logic [7:0] CAPTURE_MASK = 8'b0111_0000,
    parameter int         N_SENTINEL   = 4096
) (
    input  logic                        CLK_i,
    input  logic                        RST_i,
    pipe_stage2_collector_if.slave      bus
);
    localparam int PW = PARALLEL * WIDTH;
    localparam int EW = 3 + 2 * PW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];

    logic            any_real;
    logic            capture_en;
    logic            out_valid;
    logic            pop;
    logic            push;
    logic            full;
    logic [EW-1:0]   head;

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

        // Stage 6 carries center ids; a beat where every lane is the
        // sentinel is a "no hit" and is not worth a FIFO slot.
        any_real = 1'b0;
        for (int l = 0; l < PARALLEL; l++) begin
            if (bus.operand1_i[l*WIDTH +: WIDTH] != WIDTH'(N_SENTINEL)) any_real = 1'b1;
        end

        capture_en = (state_q == S_COLLECT) && CAPTURE_MASK[bus.stage_i]
                     && ((bus.stage_i != 3'd6) || any_real);
        out_valid  = ((state_q == S_COLLECT) || (state_q == S_DRAIN)) && (count_q != '0);
        pop        = out_valid && bus.out_ready_i;
        full       = (count_q == CW'(DEPTH));
        // A full FIFO still takes the beat when the head leaves this cycle.
        push       = capture_en && (!full || pop);

        if (capture_en && !push) overflow_d = 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = {bus.stage_i, bus.operand1_i, bus.operand2_i};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d    = S_COLLECT;
                    overflow_d = 1'b0;
                end
            end
            S_COLLECT: if (bus.finished_i) state_d = S_DRAIN;
            S_DRAIN:   if (count_d == '0) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        head            = mem_q[rd_ptr_q];
        bus.out_valid_o = out_valid;
        bus.out_stage_o = out_valid ? head[EW-1 -: 3] : 3'd0;
        bus.out_data_o  = '0;
        if (out_valid) begin
            for (int l = 0; l < PARALLEL; l++) begin
                bus.out_data_o[l*2*WIDTH +: 2*WIDTH] =
                    {head[PW + l*WIDTH +: WIDTH], head[l*WIDTH +: WIDTH]};
            end
        end
        // One spare slot absorbs the beat already in flight when stall rises.
        bus.stall_o     = (state_q == S_COLLECT) && (count_q >= CW'(DEPTH - 1));
        bus.count_o     = count_q;
        bus.done_o      = (state_q == S_DONE);
        bus.overflow_o  = overflow_q;
    end
endmodule

// File: tb/tb_pipe_stage2_collector.sv
// Directed bench for pipe_stage2_collector: capture/drop rules, FIFO order,
// full/overflow, drain/done sequencing and asynchronous reset.
module tb_pipe_stage2_collector;
    logic CLK_i = 1'b0;
    logic RST_i = 1'b1;
    int   n_tests = 0;
    int   n_failed = 0;

    always #5 CLK_i = ~CLK_i;

    pipe_stage2_collector_if #(.PARALLEL(2), .WIDTH(16), .DEPTH(8)) bus ();

    pipe_stage2_collector #(
        .PARALLEL(2), .WIDTH(16), .DEPTH(8),
        .CAPTURE_MASK(8'b0111_0000), .N_SENTINEL(4096)
    ) dut (
        .CLK_i (CLK_i),
        .RST_i (RST_i),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    function automatic logic [15:0] op1_lane(input int l);
        return bus.out_data_o[l*32+16 +: 16];
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"},    64'(bus.stall_o),     64'd0);
        chk({tag, "_valid"},    64'(bus.out_valid_o), 64'd0);
        chk({tag, "_data"},     bus.out_data_o,       64'd0);
        chk({tag, "_stage"},    64'(bus.out_stage_o), 64'd0);
        chk({tag, "_count"},    64'(bus.count_o),     64'd0);
        chk({tag, "_done"},     64'(bus.done_o),      64'd0);
        chk({tag, "_overflow"}, 64'(bus.overflow_o),  64'd0);
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.stage_i     = 3'd0;
        bus.finished_i  = 1'b0;
        bus.operand1_i  = '0;
        bus.operand2_i  = '0;
        bus.out_ready_i = 1'b0;

        // Reset state
        tick();
        tick();
        chk_quiet("reset");
        RST_i = 1'b0;
        tick();
        chk_quiet("post_reset");

        // Stage 4 beats flow through one cycle after sampling
        bus.start_i = 1'b1;
        tick();
        bus.start_i     = 1'b0;
        bus.stage_i     = 3'd4;
        bus.out_ready_i = 1'b1;
        bus.operand2_i  = {16'h2222, 16'h1111};
        bus.operand1_i  = {16'h0000, 16'h3C00};
        chk("s4_before", 64'(bus.out_valid_o), 64'd0);
        tick();
        chk("s4_b0_valid", 64'(bus.out_valid_o), 64'd1);
        chk("s4_b0_stage", 64'(bus.out_stage_o), 64'd4);
        chk("s4_b0_data",  bus.out_data_o, 64'h0000_2222_3C00_1111);
        chk("s4_b0_count", 64'(bus.count_o), 64'd1);
        bus.operand1_i = {16'h0000, 16'h4000};
        tick();
        chk("s4_b1_op1",   64'(op1_lane(0)), 64'h4000);
        chk("s4_b1_count", 64'(bus.count_o), 64'd1);
        bus.operand1_i = {16'h0000, 16'h4200};
        tick();
        chk("s4_b2_op1",   64'(op1_lane(0)), 64'h4200);
        chk("s4_b2_stage", 64'(bus.out_stage_o), 64'd4);
        chk("s4_b2_count", 64'(bus.count_o), 64'd1);

        // Uncaptured stages 1..3
        for (int s = 1; s <= 3; s++) begin
            bus.stage_i = 3'(s);
            for (int k = 0; k < 5; k++) begin
                tick();
                chk($sformatf("nocap_s%0d_valid", s), 64'(bus.out_valid_o), 64'd0);
                chk($sformatf("nocap_s%0d_count", s), 64'(bus.count_o), 64'd0);
            end
        end

        // Stage 6 sentinel filtering
        bus.out_ready_i = 1'b0;
        bus.stage_i     = 3'd6;
        bus.operand1_i  = {16'd4096, 16'd4096};
        tick();
        chk("s6_drop_count", 64'(bus.count_o), 64'd0);
        chk("s6_drop_valid", 64'(bus.out_valid_o), 64'd0);
        bus.operand1_i = {16'd4096, 16'd12};
        tick();
        chk("s6_keep_count", 64'(bus.count_o), 64'd1);
        chk("s6_keep_stage", 64'(bus.out_stage_o), 64'd6);
        chk("s6_keep_l0",    64'(op1_lane(0)), 64'd12);
        chk("s6_keep_l1",    64'(op1_lane(1)), 64'd4096);
        bus.stage_i     = 3'd0;
        bus.out_ready_i = 1'b1;
        tick();
        chk("s6_pop_count", 64'(bus.count_o), 64'd0);

        // Fill, stall, overflow
        bus.out_ready_i = 1'b0;
        bus.stage_i     = 3'd5;
        bus.operand1_i  = {16'h0000, 16'd1};
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("fill%0d_count", k), 64'(bus.count_o), 64'(k));
            chk($sformatf("fill%0d_stall", k), 64'(bus.stall_o), (k >= 7) ? 64'd1 : 64'd0);
            chk($sformatf("fill%0d_head", k),  64'(op1_lane(0)), 64'd1);
            bus.operand1_i = {16'h0000, 16'(k + 1)};
        end
        chk("full_no_ovf", 64'(bus.overflow_o), 64'd0);
        tick();
        chk("ovf_count", 64'(bus.count_o), 64'd8);
        chk("ovf_flag",  64'(bus.overflow_o), 64'd1);
        chk("ovf_head",  64'(op1_lane(0)), 64'd1);
        bus.operand1_i  = {16'h0000, 16'd10};
        bus.out_ready_i = 1'b1;
        tick();
        chk("pp_count", 64'(bus.count_o), 64'd8);
        chk("pp_head",  64'(op1_lane(0)), 64'd2);
        chk("pp_ovf",   64'(bus.overflow_o), 64'd1);
        bus.stage_i = 3'd0;
        for (int k = 3; k <= 8; k++) begin
            tick();
            chk($sformatf("empty_head%0d", k), 64'(op1_lane(0)), 64'(k));
        end
        tick();
        chk("empty_head10", 64'(op1_lane(0)), 64'd10);
        tick();
        chk("empty_count", 64'(bus.count_o), 64'd0);

        // Buffer 5, finish, drain
        bus.out_ready_i = 1'b0;
        bus.stage_i     = 3'd4;
        for (int k = 1; k <= 5; k++) begin
            bus.operand1_i = {16'h0000, 16'(16'h20 + k)};
            tick();
        end
        chk("buf5_count", 64'(bus.count_o), 64'd5);
        bus.stage_i    = 3'd0;
        bus.finished_i = 1'b1;
        tick();
        bus.finished_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        chk("drain_done_early", 64'(bus.done_o), 64'd0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("drain%0d_valid", k), 64'(bus.out_valid_o), 64'd1);
            chk($sformatf("drain%0d_head", k),  64'(op1_lane(0)), 64'(16'h21 + k));
            tick();
        end
        chk("done_pulse", 64'(bus.done_o), 64'd1);
        chk("done_valid", 64'(bus.out_valid_o), 64'd0);
        chk("done_count", 64'(bus.count_o), 64'd0);
        tick();
        chk("idle_done",  64'(bus.done_o), 64'd0);
        chk("idle_valid", 64'(bus.out_valid_o), 64'd0);
        chk("idle_ovf_sticky", 64'(bus.overflow_o), 64'd1);

        // Start clears overflow; reset mid-collect discards entries
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("start_clr_ovf", 64'(bus.overflow_o), 64'd0);
        bus.out_ready_i = 1'b0;
        bus.stage_i     = 3'd5;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_count", 64'(bus.count_o), 64'd4);
        chk("pre_rst_valid", 64'(bus.out_valid_o), 64'd1);
        RST_i = 1'b1;
        #1;
        chk_quiet("mid_rst");
        tick();
        RST_i = 1'b0;
        tick();
        chk("after_rst_count", 64'(bus.count_o), 64'd0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        bus.operand1_i = {16'h0000, 16'h0055};
        chk("restart_empty", 64'(bus.out_valid_o), 64'd0);
        tick();
        chk("restart_count", 64'(bus.count_o), 64'd1);
        chk("restart_head",  64'(op1_lane(0)), 64'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
